// File: rtl/instruction_encoder_pkg.sv
// Shared types and the field-to-word encoder used by the instruction_encoder block.
// Holds RV32I format codes, opcode constants and the immediate scatter/range-check function.
package instruction_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  // FIFO entry layout: {instr[31:0], addr[31:0], err}
  localparam int FIFO_WIDTH = 65;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } enc_fields_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_result_t;

  function automatic logic fits_i12(input logic [31:0] v);
    return v == {{20{v[11]}}, v[11:0]};
  endfunction

  function automatic logic fits_b13(input logic [31:0] v);
    return (v[0] == 1'b0) && (v == {{19{v[12]}}, v[12:0]});
  endfunction

  function automatic logic fits_j21(input logic [31:0] v);
    return (v[0] == 1'b0) && (v == {{11{v[20]}}, v[20:0]});
  endfunction

  // Erroneous words still carry the truncated fields so the loader can see what was built.
  function automatic enc_result_t encode_imm(input enc_fields_t f);
    enc_result_t r;
    r.instr = 32'h0000_0000;
    r.err   = 1'b0;
    case (f.fmt)
      FMT_R: begin
        r.instr = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
        r.err   = 1'b0;
      end
      FMT_I: begin
        r.instr = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
        r.err   = ~fits_i12(f.imm);
      end
      FMT_S: begin
        r.instr = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
        r.err   = ~fits_i12(f.imm);
      end
      FMT_B: begin
        r.instr = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                   f.imm[4:1], f.imm[11], f.opcode};
        r.err   = ~fits_b13(f.imm);
      end
      FMT_U: begin
        r.instr = {f.imm[31:12], f.rd, f.opcode};
        r.err   = (f.imm[11:0] != 12'h000);
      end
      FMT_J: begin
        r.instr = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
        r.err   = ~fits_j21(f.imm);
      end
      default: begin
        r.instr = 32'h0000_0000;
        r.err   = 1'b1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instruction_encoder_enc_fifo.sv
// Small synchronous FIFO for encoded words with flush and simultaneous push/pop.
// Head entry is read straight from the storage registers so outputs are registered.
module instruction_encoder_enc_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (AW+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy; flush empties the queue but leaves stale data in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: builds words from discrete fields, range-checks the immediate,
// tags each word with its load address and buffers the result in a small FIFO.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        restart,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  enc_fields_t           fields_s;
  enc_result_t           enc_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  empty_s;
  logic [FIFO_WIDTH-1:0] wdata_s;
  logic [FIFO_WIDTH-1:0] rdata_s;
  logic [31:0]           addr_r;
  logic [15:0]           enc_count_r;
  logic [15:0]           err_count_r;

  assign fields_s.fmt    = in_fmt;
  assign fields_s.opcode = in_opcode;
  assign fields_s.rd     = in_rd;
  assign fields_s.rs1    = in_rs1;
  assign fields_s.rs2    = in_rs2;
  assign fields_s.funct3 = in_funct3;
  assign fields_s.funct7 = in_funct7;
  assign fields_s.imm    = in_imm;

  assign enc_s = encode_imm(fields_s);

  // rst_n gates in_ready so nothing looks acceptable while the block is held in reset.
  assign in_ready = rst_n & ~full_s & ~restart;
  assign push_s   = in_valid & in_ready;
  assign pop_s    = ~empty_s & out_ready & ~restart;
  assign wdata_s  = {enc_s.instr, addr_r, enc_s.err};

  instruction_encoder_enc_fifo #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (restart),
    .push  (push_s),
    .wdata (wdata_s),
    .pop   (pop_s),
    .rdata (rdata_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign out_valid = ~empty_s;
  assign out_instr = rdata_s[64:33];
  assign out_addr  = rdata_s[32:1];
  assign out_err   = rdata_s[0];
  assign enc_count = enc_count_r;
  assign err_count = err_count_r;

  // Load address and saturating word/error counters, all cleared by restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r      <= BASE_ADDR;
      enc_count_r <= 16'h0000;
      err_count_r <= 16'h0000;
    end else if (restart) begin
      addr_r      <= BASE_ADDR;
      enc_count_r <= 16'h0000;
      err_count_r <= 16'h0000;
    end else if (push_s) begin
      addr_r <= addr_r + 32'd4;
      if (enc_count_r != 16'hFFFF) begin
        enc_count_r <= enc_count_r + 16'd1;
      end else begin
        enc_count_r <= enc_count_r;
      end
      if (enc_s.err && (err_count_r != 16'hFFFF)) begin
        err_count_r <= err_count_r + 16'd1;
      end else begin
        err_count_r <= err_count_r;
      end
    end else begin
      addr_r      <= addr_r;
      enc_count_r <= enc_count_r;
      err_count_r <= err_count_r;
    end
  end

endmodule
